// File: rtl/prach_hb1_pp.sv
// Polyphase pairing ahead of the first PRACH half-band decimator.
// Pairs consecutive per-channel TDM samples into (dp2=earlier, dp1=later).
module prach_hb1_pp #(
  parameter int NUM_CHANNEL = 16,
  parameter int WIDTH       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din_dq,
  input  logic             din_dv,
  input  logic [7:0]       din_chn,
  input  logic             sync_in,
  output logic [WIDTH-1:0] dout_dp1,
  output logic [WIDTH-1:0] dout_dp2,
  output logic             dout_dv,
  output logic [7:0]       dout_chn,
  output logic             sync_out,
  output logic             err_sync
);

  localparam int CW = (NUM_CHANNEL > 1) ? $clog2(NUM_CHANNEL) : 1;

  logic [NUM_CHANNEL-1:0] r_phase;
  logic [WIDTH:0]         r_mem [NUM_CHANNEL];

  logic             r_s1_vld;
  logic             r_s1_err;
  logic [WIDTH:0]   r_s1_rd;
  logic [WIDTH-1:0] r_s1_dp1;
  logic [7:0]       r_s1_chn;

  logic          w_chn_ok;
  logic [CW-1:0] w_idx;
  logic          w_sync;
  logic          w_wr;
  logic          w_rd;
  logic          w_err;

  assign w_chn_ok = ({24'd0, din_chn} < 32'(NUM_CHANNEL));
  assign w_idx    = din_chn[CW-1:0];
  assign w_sync   = din_dv & sync_in;
  assign w_wr     = din_dv & w_chn_ok & (sync_in | ~r_phase[w_idx]);
  assign w_rd     = din_dv & w_chn_ok & ~sync_in & r_phase[w_idx];
  assign w_err    = w_sync & (|r_phase);

  // Sync clears every channel, then the sync sample opens its own pair.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_phase <= '0;
    end else begin
      if (w_sync)
        r_phase <= '0;
      if (w_wr)
        r_phase[w_idx] <= 1'b1;
      else if (w_rd)
        r_phase[w_idx] <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr)
      r_mem[w_idx] <= {sync_in, din_dq};
  end

  // The read samples the array at the edge after the phase-0 write
  // has landed, so the back-to-back case reads the fresh value.
  always_ff @(posedge clk) begin
    if (w_rd) begin
      r_s1_rd  <= r_mem[w_idx];
      r_s1_dp1 <= din_dq;
      r_s1_chn <= din_chn;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_vld <= 1'b0;
      r_s1_err <= 1'b0;
    end else begin
      r_s1_vld <= w_rd;
      r_s1_err <= w_err;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dout_dp1 <= '0;
      dout_dp2 <= '0;
      dout_dv  <= 1'b0;
      dout_chn <= '0;
      sync_out <= 1'b0;
      err_sync <= 1'b0;
    end else begin
      dout_dv  <= r_s1_vld;
      sync_out <= r_s1_vld & r_s1_rd[WIDTH];
      err_sync <= r_s1_err;
      if (r_s1_vld) begin
        dout_dp1 <= r_s1_dp1;
        dout_dp2 <= r_s1_rd[WIDTH-1:0];
        dout_chn <= r_s1_chn;
      end
    end
  end

endmodule

// File: tb/tb_prach_hb1_pp.sv
// Scoreboard bench for prach_hb1_pp: expected pairs and err pulses
// are queued when stimulus is driven and checked as the DUT emits.
module tb_prach_hb1_pp;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] din_dq = '0;
  logic        din_dv = 1'b0;
  logic [7:0]  din_chn = '0;
  logic        sync_in = 1'b0;
  logic [15:0] dout_dp1;
  logic [15:0] dout_dp2;
  logic        dout_dv;
  logic [7:0]  dout_chn;
  logic        sync_out;
  logic        err_sync;

  prach_hb1_pp #(.NUM_CHANNEL(16), .WIDTH(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .din_dq   (din_dq),
    .din_dv   (din_dv),
    .din_chn  (din_chn),
    .sync_in  (sync_in),
    .dout_dp1 (dout_dp1),
    .dout_dp2 (dout_dp2),
    .dout_dv  (dout_dv),
    .dout_chn (dout_chn),
    .sync_out (sync_out),
    .err_sync (err_sync)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] dp1;
    logic [15:0] dp2;
    logic [7:0]  chn;
    logic        sync;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int   eq[$];
  int   cyc = 0;
  int   tests = 0;
  int   failed = 0;
  int   n_pairs = 0;

  logic [15:0] m_phase = '0;
  logic [15:0] m_mem [16];
  logic        m_sync [16];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    exp_t e;
    int   ec;
    if (dout_dv === 1'b1) begin
      n_pairs++;
      tests++;
      if (q.size() == 0) begin
        failed++;
        $display("FAIL pair_unexpected: got dp2=%h dp1=%h chn=%0d cyc=%0d, required no pair",
                 dout_dp2, dout_dp1, dout_chn, cyc);
      end else begin
        e = q.pop_front();
        if ({dout_dp1, dout_dp2, dout_chn, sync_out} !== {e.dp1, e.dp2, e.chn, e.sync}
            || cyc != e.cyc) begin
          failed++;
          $display("FAIL pair: got dp2=%h dp1=%h chn=%0d sync=%b cyc=%0d, required dp2=%h dp1=%h chn=%0d sync=%b cyc=%0d",
                   dout_dp2, dout_dp1, dout_chn, sync_out, cyc,
                   e.dp2, e.dp1, e.chn, e.sync, e.cyc);
        end
      end
    end
    if (sync_out === 1'b1 && dout_dv !== 1'b1) begin
      tests++;
      failed++;
      $display("FAIL sync_alone: got sync_out=1 dv=%b cyc=%0d, required sync_out only with dv", dout_dv, cyc);
    end
    if (err_sync === 1'b1) begin
      tests++;
      if (eq.size() == 0) begin
        failed++;
        $display("FAIL err_unexpected: got err_sync=1 cyc=%0d, required 0", cyc);
      end else begin
        ec = eq.pop_front();
        if (cyc != ec) begin
          failed++;
          $display("FAIL err_time: got err_sync at cyc=%0d, required cyc=%0d", cyc, ec);
        end
      end
    end
  end

  task automatic drive(input logic dv, input logic [7:0] c,
                       input logic [15:0] d, input logic s);
    exp_t x;
    @(posedge clk);
    #1;
    din_dv  = dv;
    din_chn = c;
    din_dq  = d;
    sync_in = s;
    if (dv) begin
      if (s) begin
        if (|m_phase) eq.push_back(cyc + 2);
        m_phase = '0;
      end
      if (c < 16) begin
        if (!m_phase[c[3:0]]) begin
          m_mem[c[3:0]]   = d;
          m_sync[c[3:0]]  = s;
          m_phase[c[3:0]] = 1'b1;
        end else begin
          x.dp1  = d;
          x.dp2  = m_mem[c[3:0]];
          x.chn  = c;
          x.sync = m_sync[c[3:0]];
          x.cyc  = cyc + 2;
          q.push_back(x);
          m_phase[c[3:0]] = 1'b0;
        end
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 8'hEE, 16'hDEAD, 1'b1);
  endtask

  task automatic do_reset(input int n);
    exp_t kq[$];
    int   ke[$];
    int   k;
    @(posedge clk);
    #1;
    rst     = 1'b1;
    din_dv  = 1'b0;
    sync_in = 1'b0;
    k = cyc;
    foreach (q[i]) if (q[i].cyc <= k) kq.push_back(q[i]);
    foreach (eq[i]) if (eq[i] <= k) ke.push_back(eq[i]);
    q  = kq;
    eq = ke;
    m_phase = '0;
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests++;
    if ({dout_dp1, dout_dp2, dout_dv, dout_chn, sync_out, err_sync} !== 43'd0) begin
      failed++;
      $display("FAIL reset_outputs: got dp1=%h dp2=%h dv=%b chn=%h sync=%b err=%b, required all 0",
               dout_dp1, dout_dp2, dout_dv, dout_chn, sync_out, err_sync);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_round_robin();
    for (int k = 0; k < 4; k++)
      for (int c = 0; c < 16; c++)
        drive(1'b1, 8'(c), 16'(16 * k + c), 1'b0);
    idle(4);
  endtask

  task automatic test_sync_marker();
    for (int c = 0; c < 3; c++) drive(1'b1, 8'(c), 16'(c), 1'b0);
    drive(1'b1, 8'd3, 16'h1234, 1'b1);
    for (int c = 4; c < 16; c++) drive(1'b1, 8'(c), 16'(c + 16'h40), 1'b0);
    for (int c = 0; c < 16; c++)
      drive(1'b1, 8'(c), (c == 3) ? 16'h5678 : 16'(c + 16'h80), 1'b0);
    for (int c = 0; c < 3; c++) drive(1'b1, 8'(c), 16'(c + 16'hC0), 1'b0);
    idle(4);
  endtask

  task automatic test_bypass();
    drive(1'b1, 8'd20, 16'h0, 1'b1);
    drive(1'b1, 8'd5, 16'hAAAA, 1'b0);
    drive(1'b1, 8'd5, 16'h5555, 1'b0);
    idle(4);
  endtask

  task automatic test_err_sync();
    drive(1'b1, 8'd7, 16'h0100, 1'b0);
    idle(1);
    drive(1'b1, 8'd2, 16'h0022, 1'b1);
    drive(1'b1, 8'd7, 16'h0200, 1'b0);
    drive(1'b1, 8'd7, 16'h0300, 1'b0);
    drive(1'b1, 8'd2, 16'h0023, 1'b0);
    idle(4);
  endtask

  task automatic test_bad_chn();
    drive(1'b1, 8'd0, 16'h000A, 1'b0);
    drive(1'b1, 8'd20, 16'hBEEF, 1'b0);
    drive(1'b0, 8'd0, 16'hCAFE, 1'b0);
    drive(1'b1, 8'd0, 16'h000B, 1'b0);
    drive(1'b1, 8'd0, 16'h000C, 1'b0);
    drive(1'b1, 8'd0, 16'h000D, 1'b0);
    idle(4);
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 8'd1, 16'h0099, 1'b0);
    do_reset(1);
    drive(1'b1, 8'd1, 16'h0011, 1'b0);
    drive(1'b1, 8'd1, 16'h0022, 1'b0);
    drive(1'b1, 8'd4, 16'h0001, 1'b0);
    drive(1'b1, 8'd4, 16'h0002, 1'b0);
    do_reset(2);
    drive(1'b1, 8'd4, 16'h0003, 1'b0);
    drive(1'b1, 8'd4, 16'h0004, 1'b0);
    idle(4);
  endtask

  task automatic test_back_to_back();
    int p0;
    drive(1'b1, 8'd20, 16'h0, 1'b1);
    idle(3);
    p0 = n_pairs;
    for (int k = 0; k < 2; k++)
      for (int c = 0; c < 16; c++)
        drive(1'b1, 8'(c), 16'($urandom), 1'b0);
    idle(4);
    tests++;
    if (n_pairs - p0 != 16) begin
      failed++;
      $display("FAIL b2b_count: got %0d pairs, required 16", n_pairs - p0);
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_sync_marker();
    test_bypass();
    test_err_sync();
    test_bad_chn();
    test_reset_mid();
    test_back_to_back();
    idle(6);
    tests++;
    if (q.size() != 0 || eq.size() != 0) begin
      failed++;
      $display("FAIL drain: got %0d pairs and %0d err pulses outstanding, required 0",
               q.size(), eq.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/prach_hb1_pp.md
# prach_hb1_pp

Polyphase pairing stage that sits directly upstream of the first PRACH half-band decimator (`prach_hb1_ch`). It accepts a TDM stream of up to 16 channels at the pre-decimation rate, one sample per valid cycle. For each channel it pairs consecutive samples into an (earlier, later) polyphase pair and emits one pair per channel per two input samples, in the `dp1`/`dp2` format the half-band consumes. The sync marker travels with the sample that carried it and is re-emitted on the pair that sample belongs to.

## Interface

Parameters:
- `NUM_CHANNEL`, 16: number of TDM channels; valid `din_chn` range is 0..NUM_CHANNEL-1.
- `WIDTH`, 16: sample width in bits, two's complement.

Ports:
- `clk` in 1: single clock; all logic is on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `din_dq` in WIDTH: input sample.
- `din_dv` in 1: input valid; may be high on consecutive cycles.
- `din_chn` in 8: channel index of `din_dq`.
- `sync_in` in 1: frame restart marker; qualified by `din_dv`.
- `dout_dp1` out WIDTH: later (phase-1) sample of the pair.
- `dout_dp2` out WIDTH: earlier (phase-0) sample of the pair.
- `dout_dv` out 1: one-cycle pulse per emitted pair.
- `dout_chn` out 8: channel index of the pair.
- `sync_out` out 1: pulses with the pair whose phase-0 sample carried `sync_in`.
- `err_sync` out 1: one-cycle pulse when a sync discards pending phase-0 samples.

## Operation

State held by the block:
- `phase[NUM_CHANNEL]`: one bit per channel; 0 means a phase-0 sample is expected.
- Sample memory: NUM_CHANNEL x (WIDTH+1), holding the phase-0 sample plus its sync bit. The memory is not reset; its contents are don't-care until written.

Per valid input cycle with `din_chn` < NUM_CHANNEL:
- **Phase 0** (`phase[c]=0`, or `sync_in=1`):
  - Write {`sync_in`, `din_dq`} to mem[c] and set `phase[c]=1`.
  - No output is produced.
- **Phase 1** (`phase[c]=1` and `sync_in=0`):
  - Read mem[c] and clear `phase[c]`.
  - Emit `dout_dp2`=mem sample, `dout_dp1`=`din_dq`, `dout_chn`=c, `sync_out`=mem sync bit, `dout_dv`=1.

Sync handling (`sync_in=1` with `din_dv=1`):
- First clear all `phase` bits, then treat the current sample as phase 0 of its channel.
- If any `phase` bit was 1 before the clear, pulse `err_sync` 2 cycles later. The discarded halves are never output.

Ignored inputs:
- `din_dv=0`: `din_dq`, `din_chn` and `sync_in` are ignored.
- `din_chn` >= NUM_CHANNEL with `din_dv=1`: the sample is dropped and no state changes, except that the sync clear and `err_sync` still apply when `sync_in=1`.

Write-then-read hazard: a phase-1 sample for channel c on the cycle immediately after the phase-0 write for c must return the just-written value. This requires a write-first path or a bypass.

Output rate: at most one pair per 2 valid inputs per channel. `dout_dv` never exceeds the input valid rate.

## Timing

- Latency: a phase-1 input at cycle N produces `dout_*` at cycle N+2, fixed. One cycle is for the registered memory read, one for the output register.
- `dout_dv`, `sync_out` and `err_sync` are single-cycle pulses.
- `dout_dp1`, `dout_dp2` and `dout_chn` hold their last values between pulses.
- Reset values: all outputs 0 and all `phase` bits 0.
- While `rst=1`, any in-flight pair in the 2-cycle pipeline is squashed: no `dout_dv` is produced.
- The first valid sample after reset is phase 0 for every channel.
- Reset mid-pair: the pending phase-0 samples are lost silently, with no `err_sync`.
- Back-to-back traffic at full rate (`din_dv` high every cycle, channels 0..15 repeating) yields 16 output pulses per 32 input cycles, with no stall and no drop.

## Test plan

- Reset, then ch0..15 round-robin with `din_dq`=16·k+c on sample k, `din_dv` high every cycle:
  - Expect pairs (dp2, dp1)=(32m+c, 32m+16+c) for each channel c, in channel order.
  - Each pair appears 2 cycles after its phase-1 input.
- `sync_in=1` on the ch3 sample of value 0x1234, with ch3's next sample 0x5678:
  - Expect `sync_out=1` only with the ch3 pair (dp2=0x1234, dp1=0x5678).
  - All other pairs have `sync_out=0`.
- Single channel, back-to-back ch5 samples 0xAAAA then 0x5555 on adjacent cycles:
  - Expect dp2=0xAAAA, dp1=0x5555, which exercises the write-then-read bypass.
- Send a ch7 phase-0 sample 0x0100, then `sync_in` on ch2:
  - Expect `err_sync` pulse 2 cycles after the sync input.
  - The next two ch7 samples 0x0200 and 0x0300 must pair as (0x0200, 0x0300), and 0x0100 is never output.
- `din_chn`=20 with `din_dv=1`:
  - Expect no output and no phase change.
  - A subsequent ch0 sequence pairs normally.
- Assert `rst` for 1 cycle between a phase-0 and phase-1 sample of ch1:
  - Expect no `dout_dv` for that pair and no `err_sync`.
  - The next ch1 samples 0x0011 and 0x0022 pair as (0x0011, 0x0022).
